// File: rtl/apb_pkg.sv
// Shared types and default widths for the arbitrated APB master.
package apb_pkg;

  localparam int unsigned DefaultAddrW = 32;
  localparam int unsigned DefaultDataW = 32;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess
  } apb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: the requester named by ptr_i wins a tie.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

  logic alt;
  assign alt = ~ptr_i;

  always_comb begin
    gnt_o = 2'b00;
    if (req_i[ptr_i]) begin
      gnt_o[ptr_i] = 1'b1;
    end else if (req_i[alt]) begin
      gnt_o[alt] = 1'b1;
    end
  end

endmodule

// File: rtl/apb_arb_master.sv
// APB master shared by two requesters, round-robin arbitrated, with an ACCESS timeout.
module apb_arb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefaultAddrW,
  parameter int unsigned DATA_W  = DefaultDataW,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic [1:0]          req_i,
  input  logic [1:0]          cmd_write_i,
  input  logic [2*ADDR_W-1:0] cmd_addr_i,
  input  logic [2*DATA_W-1:0] cmd_wdata_i,
  output logic [1:0]          gnt_o,
  output logic [1:0]          done_o,
  output logic                err_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                psel_o,
  output logic                penable_o,
  output logic                pwrite_o,
  output logic [ADDR_W-1:0]   paddr_o,
  output logic [DATA_W-1:0]   pwdata_o,
  input  logic [DATA_W-1:0]   prdata_i,
  input  logic                pready_i
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  apb_state_e        state_q;
  logic              ptr_q;
  logic              sel_q;
  logic [CntW-1:0]   cnt_q;
  logic [1:0]        gnt_q;
  logic [1:0]        done_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;

  logic [1:0] arb_gnt;
  logic       arb_idx;

  rr_arb2 u_rr_arb2 (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt)
  );

  assign arb_idx = arb_gnt[1];

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= StIdle;
      ptr_q     <= 1'b0;
      sel_q     <= 1'b0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      // Completion flags are single-cycle pulses.
      done_q <= '0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|req_i) begin
            state_q  <= StSetup;
            psel_q   <= 1'b1;
            gnt_q    <= arb_gnt;
            sel_q    <= arb_idx;
            ptr_q    <= ~arb_idx;
            cnt_q    <= '0;
            pwrite_q <= cmd_write_i[arb_idx];
            paddr_q  <= cmd_addr_i[arb_idx*ADDR_W +: ADDR_W];
            pwdata_q <= cmd_wdata_i[arb_idx*DATA_W +: DATA_W];
          end
        end
        StSetup: begin
          state_q   <= StAccess;
          penable_q <= 1'b1;
          gnt_q     <= '0;
        end
        StAccess: begin
          // A ready slave wins over a timeout landing in the same cycle.
          if (pready_i || (cnt_q == CntW'(TIMEOUT - 1))) begin
            state_q   <= StIdle;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            done_q    <= sel_q ? 2'b10 : 2'b01;
            err_q     <= ~pready_i;
            rdata_q   <= (pready_i && !pwrite_q) ? prdata_i : '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt_o     = gnt_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign rdata_o   = rdata_q;
  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign pwrite_o  = pwrite_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;

endmodule

// File: tb/tb_apb_arb_master.sv
// Directed bench for apb_arb_master: read, waited write, round-robin, timeout, mid-transfer reset.
module tb_apb_arb_master;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          pclk = 1'b0;
  logic          preset;
  logic [1:0]    req_i;
  logic [1:0]    cmd_write_i;
  logic [2*AW-1:0] cmd_addr_i;
  logic [2*DW-1:0] cmd_wdata_i;
  logic [1:0]    gnt_o;
  logic [1:0]    done_o;
  logic          err_o;
  logic [DW-1:0] rdata_o;
  logic          psel_o;
  logic          penable_o;
  logic          pwrite_o;
  logic [AW-1:0] paddr_o;
  logic [DW-1:0] pwdata_o;
  logic [DW-1:0] prdata_i;
  logic          pready_i;

  int n_cmp = 0;
  int n_err = 0;

  apb_arb_master #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (16)
  ) dut (
    .pclk        (pclk),
    .preset      (preset),
    .req_i       (req_i),
    .cmd_write_i (cmd_write_i),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_wdata_i (cmd_wdata_i),
    .gnt_o       (gnt_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .rdata_o     (rdata_o),
    .psel_o      (psel_o),
    .penable_o   (penable_o),
    .pwrite_o    (pwrite_o),
    .paddr_o     (paddr_o),
    .pwdata_o    (pwdata_o),
    .prdata_i    (prdata_i),
    .pready_i    (pready_i)
  );

  always #5 pclk = ~pclk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic do_reset();
    preset   = 1'b1;
    req_i    = 2'b00;
    pready_i = 1'b0;
    tick();
    tick();
    preset = 1'b0;
  endtask

  initial begin
    preset      = 1'b1;
    req_i       = 2'b00;
    cmd_write_i = 2'b00;
    cmd_addr_i  = '0;
    cmd_wdata_i = '0;
    prdata_i    = '0;
    pready_i    = 1'b0;
    do_reset();

    // Reset state
    check_eq("rst_psel", psel_o, 0);
    check_eq("rst_penable", penable_o, 0);
    check_eq("rst_pwrite", pwrite_o, 0);
    check_eq("rst_paddr", paddr_o, 0);
    check_eq("rst_pwdata", pwdata_o, 0);
    check_eq("rst_rdata", rdata_o, 0);
    check_eq("rst_gnt", gnt_o, 0);
    check_eq("rst_done", done_o, 0);
    check_eq("rst_err", err_o, 0);

    // Single read from requester 0, ready on first ACCESS
    req_i       = 2'b01;
    cmd_write_i = 2'b00;
    cmd_addr_i  = {32'h0000_0099, 32'h0000_0010};
    prdata_i    = 32'h1F;
    pready_i    = 1'b1;
    tick();
    req_i = 2'b00;
    check_eq("rd_setup_psel", psel_o, 1);
    check_eq("rd_setup_penable", penable_o, 0);
    check_eq("rd_setup_gnt", gnt_o, 2'b01);
    check_eq("rd_setup_paddr", paddr_o, 32'h10);
    check_eq("rd_setup_pwrite", pwrite_o, 0);
    tick();
    check_eq("rd_access_penable", penable_o, 1);
    check_eq("rd_access_gnt", gnt_o, 0);
    check_eq("rd_access_done", done_o, 0);
    tick();
    check_eq("rd_done", done_o, 2'b01);
    check_eq("rd_rdata", rdata_o, 32'h1F);
    check_eq("rd_err", err_o, 0);
    check_eq("rd_idle_psel", psel_o, 0);
    check_eq("rd_idle_paddr_hold", paddr_o, 32'h10);
    tick();
    check_eq("rd_done_pulse", done_o, 0);

    // Write from requester 1 with three wait states
    req_i       = 2'b10;
    cmd_write_i = 2'b10;
    cmd_addr_i  = {32'h0000_0020, 32'h0000_0044};
    cmd_wdata_i = {32'hDEAD_BEEF, 32'h1111_2222};
    pready_i    = 1'b0;
    tick();
    req_i       = 2'b00;
    cmd_addr_i  = '0;
    cmd_wdata_i = '0;
    check_eq("wr_setup_gnt", gnt_o, 2'b10);
    check_eq("wr_setup_pwrite", pwrite_o, 1);
    check_eq("wr_setup_paddr", paddr_o, 32'h20);
    check_eq("wr_setup_pwdata", pwdata_o, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq($sformatf("wr_acc%0d_penable", i), penable_o, 1);
      check_eq($sformatf("wr_acc%0d_paddr", i), paddr_o, 32'h20);
      check_eq($sformatf("wr_acc%0d_pwdata", i), pwdata_o, 32'hDEAD_BEEF);
      check_eq($sformatf("wr_acc%0d_done", i), done_o, 0);
      if (i == 3) pready_i = 1'b1;
    end
    tick();
    check_eq("wr_done", done_o, 2'b10);
    check_eq("wr_rdata_zero", rdata_o, 0);
    check_eq("wr_err", err_o, 0);
    check_eq("wr_idle_psel", psel_o, 0);

    // Round-robin alternation with both requesting continuously
    do_reset();
    cmd_write_i = 2'b00;
    cmd_addr_i  = {32'h0000_0B00, 32'h0000_0A00};
    prdata_i    = 32'h55;
    pready_i    = 1'b1;
    req_i       = 2'b11;
    for (int t = 0; t < 4; t++) begin
      logic [1:0] exp_oh;
      exp_oh = (t % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      check_eq($sformatf("rr%0d_gnt", t), gnt_o, exp_oh);
      check_eq($sformatf("rr%0d_paddr", t), paddr_o, (t % 2 == 0) ? 32'hA00 : 32'hB00);
      tick();
      tick();
      check_eq($sformatf("rr%0d_done", t), done_o, exp_oh);
    end
    req_i = 2'b00;
    tick();

    // Timeout with pready held low
    do_reset();
    prdata_i = 32'hAA;
    req_i    = 2'b01;
    tick();
    req_i = 2'b00;
    check_eq("to_setup_gnt", gnt_o, 2'b01);
    for (int i = 0; i < 16; i++) begin
      tick();
      if (penable_o !== 1'b1 || done_o !== 2'b00)
        check_eq($sformatf("to_access%0d", i), {penable_o, done_o}, 3'b100);
    end
    check_eq("to_still_access", {psel_o, penable_o, done_o}, 4'b1100);
    tick();
    check_eq("to_done", done_o, 2'b01);
    check_eq("to_err", err_o, 1);
    check_eq("to_rdata", rdata_o, 0);
    check_eq("to_bus_idle", {psel_o, penable_o}, 2'b00);
    tick();
    check_eq("to_err_pulse", err_o, 0);

    // Reset during ACCESS aborts and restores pointer to requester 0
    do_reset();
    pready_i = 1'b1;
    req_i    = 2'b01;
    tick();
    req_i = 2'b00;
    tick();
    tick();
    check_eq("ab_first_done", done_o, 2'b01);
    pready_i = 1'b0;
    req_i    = 2'b01;
    tick();
    req_i = 2'b00;
    tick();
    check_eq("ab_in_access", penable_o, 1);
    preset = 1'b1;
    tick();
    check_eq("ab_psel", psel_o, 0);
    check_eq("ab_penable", penable_o, 0);
    check_eq("ab_done", done_o, 0);
    preset = 1'b0;
    req_i  = 2'b11;
    tick();
    req_i = 2'b00;
    check_eq("ab_regrant", gnt_o, 2'b01);
    check_eq("ab_no_done", done_o, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
